// File: rtl/delay_timer_pkg.sv
// Shared types and constants for the programmable delay timer.
// Default widths and DHT11 timing windows assume a 50 MHz project clock.
package delay_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int DLY_CNT_W = 20;
    localparam int DLY_PRE_W = 8;

    // Prescale reload giving a 1 us tick at 50 MHz; delays below are in those ticks
    localparam int unsigned DHT_PRE_1US       = 49;
    localparam int unsigned DHT_START_LOW_US  = 18000;
    localparam int unsigned DHT_RESP_MIN_US   = 20;
    localparam int unsigned DHT_RESP_MAX_US   = 40;
    localparam int unsigned DHT_BIT_WINDOW_US = 100;

endpackage

// File: rtl/delay_timer_if.sv
// Control/status bundle between the sensor FSM (master) and the delay timer (slave).
interface delay_timer_if #(
    parameter int CNT_W = delay_pkg::DLY_CNT_W,
    parameter int PRE_W = delay_pkg::DLY_PRE_W
) ();
    logic             start;
    logic             abort;
    logic             periodic;
    logic [PRE_W-1:0] prescale;
    logic [CNT_W-1:0] delay;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] elapsed;

    modport master (
        output start, abort, periodic, prescale, delay,
        input  busy, done, elapsed
    );

    modport slave (
        input  start, abort, periodic, prescale, delay,
        output busy, done, elapsed
    );
endinterface

// File: rtl/delay_timer_tick_gen.sv
// Prescaler: emits a tick on every (pre_q+1)-th enabled clock.
module tick_gen
    import delay_pkg::*;
#(
    parameter int PRE_W = DLY_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [PRE_W-1:0] pre_q,
    output logic             tick
);
    logic [PRE_W-1:0] pre_cnt;

    assign tick = en && (pre_cnt == pre_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
        end
    end
endmodule

// File: rtl/delay_timer.sv
// One-shot/periodic delay timer with run-time prescaler and start/abort handshake.
module delay_timer
    import delay_pkg::*;
#(
    parameter int CNT_W = DLY_CNT_W,
    parameter int PRE_W = DLY_PRE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    delay_timer_if.slave bus
);
    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q;
    logic [CNT_W-1:0] dly_q;
    logic             per_q;
    logic [CNT_W-1:0] elapsed_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             load;
    logic             clr;
    logic             fin;

    tick_gen #(.PRE_W(PRE_W)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .en    (state_q == ST_RUN),
        .pre_q (pre_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort beats start, and both beat a period ending on the same edge
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clr     = 1'b0;
        fin     = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            clr     = 1'b1;
        end else if (bus.start) begin
            state_d = ST_RUN;
            load    = 1'b1;
            clr     = 1'b1;
        end else if (state_q == ST_RUN) begin
            if (dly_q == '0) begin
                fin     = 1'b1;
                state_d = ST_IDLE;
            end else if (tick && (elapsed_q + CNT_W'(1) == dly_q)) begin
                fin = 1'b1;
                if (!per_q) begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q     <= '0;
            dly_q     <= '0;
            per_q     <= 1'b0;
            elapsed_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            busy_q <= (state_d == ST_RUN);
            done_q <= fin;
            if (load) begin
                pre_q <= bus.prescale;
                dly_q <= bus.delay;
                per_q <= bus.periodic;
            end
            // Periodic runs restart at zero; one-shot holds the final count
            if (clr) begin
                elapsed_q <= '0;
            end else if (fin) begin
                elapsed_q <= per_q ? '0 : dly_q;
            end else if (tick) begin
                elapsed_q <= elapsed_q + CNT_W'(1);
            end
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.elapsed = elapsed_q;
endmodule

// File: tb/tb_delay_timer.sv
// Scoreboard bench for delay_timer: expected done events queued at launch, checked by a monitor.
module tb_delay_timer;
    logic clk;
    logic rst_n;
    int   cyc;
    int   tests;
    int   fails;

    typedef struct {
        int cyc;
        int elapsed;
        bit busy;
    } exp_t;

    exp_t sb[$];

    delay_timer_if #(.CNT_W(20), .PRE_W(8)) bus ();

    delay_timer #(.CNT_W(20), .PRE_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic expect_done(input int c, input int el, input bit bsy);
        exp_t e;
        e.cyc     = c;
        e.elapsed = el;
        e.busy    = bsy;
        sb.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done cyc=%0d got=1 expected=0", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("done_elapsed", int'(bus.elapsed), e.elapsed);
                check("done_busy", int'(bus.busy), int'(e.busy));
            end
        end
    end

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge following E0
    task automatic launch(input bit per, input int pre, input int dly, output int e0);
        bus.start    = 1'b1;
        bus.periodic = per;
        bus.prescale = 8'(pre);
        bus.delay    = 20'(dly);
        e0 = cyc + 1;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.periodic = 1'b0;
        bus.prescale = '0;
        bus.delay    = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int e0;
        int e1;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.periodic = 1'b0;
        bus.prescale = '0;
        bus.delay = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_elapsed", int'(bus.elapsed), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // One-shot, prescale 0, delay 5
        expect_done(cyc + 1 + 5, 5, 1'b0);
        launch(1'b0, 0, 5, e0);
        check("t1_busy_e0", int'(bus.busy), 1);
        check("t1_elapsed_e0", int'(bus.elapsed), 0);
        wait_to(e0 + 4);
        check("t1_busy_e4", int'(bus.busy), 1);
        check("t1_elapsed_e4", int'(bus.elapsed), 4);
        wait_to(e0 + 9);
        check("t1_busy_after", int'(bus.busy), 0);
        check("t1_elapsed_hold", int'(bus.elapsed), 5);
        check("t1_pending", sb.size(), 0);

        // Periodic, prescale 3, delay 4: period 16
        e1 = cyc + 1;
        expect_done(e1 + 16, 0, 1'b1);
        expect_done(e1 + 32, 0, 1'b1);
        expect_done(e1 + 48, 0, 1'b1);
        launch(1'b1, 3, 4, e0);
        wait_to(e0 + 8);
        check("t2_elapsed_e8", int'(bus.elapsed), 2);
        wait_to(e0 + 50);
        check("t2_busy", int'(bus.busy), 1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t2_abort_busy", int'(bus.busy), 0);
        repeat (3) @(negedge clk);
        check("t2_pending", sb.size(), 0);

        // delay 0 in periodic mode: single done then idle
        expect_done(cyc + 1 + 1, 0, 1'b0);
        launch(1'b1, 0, 0, e0);
        check("t3_busy_e0", int'(bus.busy), 1);
        wait_to(e0 + 5);
        check("t3_busy_after", int'(bus.busy), 0);
        check("t3_pending", sb.size(), 0);

        // Abort at E0+10 of a delay 20 run
        launch(1'b0, 0, 20, e0);
        wait_to(e0 + 9);
        check("t4_elapsed_e9", int'(bus.elapsed), 9);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("t4_busy_e10", int'(bus.busy), 0);
        check("t4_elapsed_e10", int'(bus.elapsed), 0);
        wait_to(e0 + 40);
        check("t4_pending", sb.size(), 0);

        // Retrigger at E0+3 with delay 2 during a delay 10 run
        launch(1'b0, 0, 10, e0);
        wait_to(e0 + 2);
        expect_done(e0 + 5, 2, 1'b0);
        launch(1'b0, 0, 2, e1);
        wait_to(e0 + 15);
        check("t5_busy", int'(bus.busy), 0);
        check("t5_pending", sb.size(), 0);

        // Retrigger on the same edge as the final tick: no done for the old run
        launch(1'b0, 0, 3, e0);
        wait_to(e0 + 2);
        expect_done(e0 + 6, 3, 1'b0);
        launch(1'b0, 0, 3, e1);
        wait_to(e0 + 10);
        check("t5b_pending", sb.size(), 0);

        // Abort and start together: stays idle, counters cleared
        bus.abort = 1'b1;
        launch(1'b0, 0, 4, e0);
        bus.abort = 1'b0;
        check("t5c_busy", int'(bus.busy), 0);
        check("t5c_elapsed", int'(bus.elapsed), 0);
        wait_to(e0 + 8);
        check("t5c_busy_later", int'(bus.busy), 0);

        // Asynchronous reset mid-run
        launch(1'b0, 0, 10, e0);
        wait_to(e0 + 4);
        check("t6_elapsed_pre", int'(bus.elapsed), 4);
        #2 rst_n = 1'b0;
        #1;
        check("t6_busy_rst", int'(bus.busy), 0);
        check("t6_elapsed_rst", int'(bus.elapsed), 0);
        check("t6_done_rst", int'(bus.done), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        check("t6_busy_after", int'(bus.busy), 0);
        check("t6_pending", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/delay_timer.md
# delay_timer

Programmable one-shot/periodic delay timer with a run-time prescaler and a start/abort/busy/done handshake. It replaces the fixed free-running delay counter as the timing primitive for the DHT11 sensor path, for example the 18 ms host start pulse, the 20–40 µs response windows and bit-period measurement. It sits between the sensor control FSM and the single-wire I/O logic. Widths are parametrised so one block covers both microsecond and millisecond ranges.

## Interface
Parameters:
- CNT_W, default 20: width of the delay and elapsed counters, in ticks.
- PRE_W, default 8: width of the prescaler reload value.

Ports:
- clk, input, 1: single system clock; all logic on rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- start, input, 1: launch or retrigger a timing run; sampled at clk edge.
- abort, input, 1: cancel the run; has priority over start.
- periodic, input, 1: 0 selects one-shot, 1 selects periodic; latched at start.
- prescale, input, PRE_W: a tick occurs every prescale+1 clk cycles; latched at start.
- delay, input, CNT_W: run length in ticks; latched at start.
- busy, output, 1: a run is in progress.
- done, output, 1: one-cycle pulse at the end of each period.
- elapsed, output, CNT_W: ticks completed in the current period.

## Operation
- Two states, IDLE and RUN. Registered copies pre_q, dly_q and per_q are taken from the inputs on start.
- In IDLE, start=1 and abort=0 latches the inputs, clears pre_cnt and elapsed, and moves to RUN.
- In RUN, each edge does one of two things:
  - If pre_cnt==pre_q, it is a tick: pre_cnt clears to 0 and elapsed increments.
  - Otherwise pre_cnt increments.
- End of period is a tick that brings elapsed to dly_q. On that edge done goes high for one cycle.
  - One-shot: go to IDLE. elapsed holds dly_q until the next start.
  - Periodic: stay in RUN and clear elapsed to 0 on the same edge. No dead cycle between periods.
- start while in RUN retriggers: the new inputs are latched and counters clear. No done is issued for the interrupted period.
- abort (any state) goes to IDLE and clears pre_cnt and elapsed. done is suppressed even if a period ends on that edge.
- delay=0: done pulses on the edge after start and the block returns to IDLE, regardless of periodic.
- prescale=0: one tick per clk.
- Inputs other than start and abort are don't-care outside the start cycle.
- The counters never wrap, since elapsed ≤ dly_q ≤ 2^CNT_W−1.

## Timing
- Reset values: busy=0, done=0, elapsed=0. State is IDLE, all latched registers are 0.
- Let E0 be the edge where start is sampled. busy=1 from E0.
- Take D=dly_q and P=pre_q. The first tick is at edge E0+(P+1). done=1 and, for one-shot, busy=0 both take effect at edge E0+D·(P+1). Latency is exactly D·(P+1) cycles.
- In periodic mode done repeats every D·(P+1) cycles.
- If start and the last tick fall on the same edge, retrigger wins and done=0.
- rst_n asserted mid-run clears everything immediately. On release the block waits in IDLE for start.
- All outputs are registered. There is no combinational path from input to output.

## Structure
- Shared package delay_pkg holds:
  - the state encoding constants ST_IDLE=1'b0 and ST_RUN=1'b1;
  - the default widths DLY_CNT_W=20 and DLY_PRE_W=8;
  - named delay constants for the DHT11 windows at the project clock.
- One natural sub-module, tick_gen, is the prescaler. It takes clk, rst_n, clr, en and pre_q, and produces a 1-cycle tick.
- delay_timer itself holds the FSM, the latch registers and the elapsed counter.

## Test plan
- Reset, prescale=0, delay=5, one-shot start at E0: busy 1 from E0, done only at E0+5, busy 0 at E0+5, elapsed=5 held afterward.
- Prescale=3, delay=4, periodic: done at E0+16, E0+32 and E0+48. elapsed is 0 after each done. busy stays 1.
- delay=0 with periodic=1: a single done at E0+1, then IDLE with busy=0.
- Abort at E0+10 of a delay=20 run (prescale=0): busy=0 and elapsed=0 at E0+10. No done through E0+40.
- Retrigger at E0+3 with delay=2 during a delay=10 run (prescale=0): done at E0+5 only, nothing at E0+10. Also abort and start together at E0: stays IDLE.
- rst_n low for 2 cycles mid-run (asynchronous, between edges): outputs go to 0 immediately, no done after release until a new start.
